// File: rtl/sram_rw_ctrl.sv
// rtl/sram_rw_ctrl.sv - read/write sequencer driving one sram_cell column
module sram_rw_ctrl #(
  parameter int  ROWS       = 4,
  parameter int  WR_CYCLES  = 4,
  parameter int  RD_CYCLES  = 3,
  parameter int  PRE_CYCLES = 2,
  parameter real VDD        = 1.5,
  parameter real VSS        = 0.0,
  localparam int AW         = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [AW-1:0]   req_addr,
  input  logic            req_wdata,
  output logic [ROWS-1:0] row_wr,
  output logic [ROWS-1:0] row_rd,
  output real             bl_wr,
  output real             blb_wr,
  output logic            pre_en,
  input  real             bl_rd,
  input  real             blb_rd,
  output logic            rsp_valid,
  output logic            rsp_rdata,
  output logic            rsp_err
);

  typedef enum logic [2:0] {
    IDLE, WR_SETUP, WR_PULSE, WR_HOLD, RD_PRE, RD_PULSE, RESP
  } state_t;

  localparam logic [ROWS-1:0] ROW_ONE = ROWS'(1);
  localparam logic [AW:0]     ROWS_W  = (AW + 1)'(ROWS);

  state_t          state_q, state_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic            ready_q, ready_d;
  logic [ROWS-1:0] row_wr_q, row_wr_d;
  logic [ROWS-1:0] row_rd_q, row_rd_d;
  logic            pre_en_q, pre_en_d;
  logic            bl_drv_q, bl_drv_d;
  logic            bl_val_q, bl_val_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic            rsp_rdata_q, rsp_rdata_d;
  logic            rsp_err_q, rsp_err_d;
  logic            last_rdata_q, last_rdata_d;

  // Next-state and next-output computation; every output is taken from a flop.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    ready_d      = ready_q;
    row_wr_d     = row_wr_q;
    row_rd_d     = row_rd_q;
    pre_en_d     = pre_en_q;
    bl_drv_d     = bl_drv_q;
    bl_val_d     = bl_val_q;
    rsp_valid_d  = 1'b0;
    rsp_rdata_d  = rsp_rdata_q;
    rsp_err_d    = rsp_err_q;
    last_rdata_d = last_rdata_q;
    case (state_q)
      IDLE: begin
        ready_d = 1'b1;
        if (req_valid && ready_q) begin
          ready_d = 1'b0;
          addr_d  = req_addr;
          if ({1'b0, req_addr} >= ROWS_W) begin
            // Unmapped row: answer immediately without touching the column.
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = 1'b0;
          end else if (req_we) begin
            state_d  = WR_SETUP;
            bl_drv_d = 1'b1;
            bl_val_d = req_wdata;
          end else begin
            state_d  = RD_PRE;
            pre_en_d = 1'b1;
            cnt_d    = 8'(PRE_CYCLES - 1);
          end
        end
      end
      WR_SETUP: begin
        state_d  = WR_PULSE;
        row_wr_d = ROW_ONE << addr_q;
        cnt_d    = 8'(WR_CYCLES - 1);
      end
      WR_PULSE: begin
        if (cnt_q == 8'd0) begin
          state_d  = WR_HOLD;
          row_wr_d = '0;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      WR_HOLD: begin
        state_d     = RESP;
        bl_drv_d    = 1'b0;
        bl_val_d    = 1'b0;
        rsp_valid_d = 1'b1;
        rsp_rdata_d = 1'b0;
        rsp_err_d   = 1'b0;
      end
      RD_PRE: begin
        if (cnt_q == 8'd0) begin
          state_d  = RD_PULSE;
          pre_en_d = 1'b0;
          row_rd_d = ROW_ONE << addr_q;
          cnt_d    = 8'(RD_CYCLES - 1);
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      RD_PULSE: begin
        if (cnt_q == 8'd0) begin
          state_d     = RESP;
          row_rd_d    = '0;
          rsp_valid_d = 1'b1;
          // A balanced bitline pair cannot be resolved: repeat the last value and flag it.
          if (bl_rd > blb_rd) begin
            rsp_rdata_d = 1'b1;
            rsp_err_d   = 1'b0;
          end else if (bl_rd < blb_rd) begin
            rsp_rdata_d = 1'b0;
            rsp_err_d   = 1'b0;
          end else begin
            rsp_rdata_d = last_rdata_q;
            rsp_err_d   = 1'b1;
          end
          last_rdata_d = rsp_rdata_d;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      RESP: begin
        state_d     = IDLE;
        ready_d     = 1'b1;
        rsp_rdata_d = 1'b0;
        rsp_err_d   = 1'b0;
      end
      default: begin
        state_d = IDLE;
        ready_d = 1'b0;
      end
    endcase
  end

  // State and registered outputs; reset clears the column drive at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= 8'd0;
      addr_q       <= '0;
      ready_q      <= 1'b0;
      row_wr_q     <= '0;
      row_rd_q     <= '0;
      pre_en_q     <= 1'b0;
      bl_drv_q     <= 1'b0;
      bl_val_q     <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_rdata_q  <= 1'b0;
      rsp_err_q    <= 1'b0;
      last_rdata_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      ready_q      <= ready_d;
      row_wr_q     <= row_wr_d;
      row_rd_q     <= row_rd_d;
      pre_en_q     <= pre_en_d;
      bl_drv_q     <= bl_drv_d;
      bl_val_q     <= bl_val_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_rdata_q  <= rsp_rdata_d;
      rsp_err_q    <= rsp_err_d;
      last_rdata_q <= last_rdata_d;
    end
  end

  // Bitline levels are decoded from the registered drive/value pair.
  assign bl_wr     = bl_drv_q ? (bl_val_q ? VDD : VSS) : VSS;
  assign blb_wr    = bl_drv_q ? (bl_val_q ? VSS : VDD) : VSS;
  assign req_ready = ready_q;
  assign row_wr    = row_wr_q;
  assign row_rd    = row_rd_q;
  assign pre_en    = pre_en_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_sram_rw_ctrl.sv
// tb/tb_sram_rw_ctrl.sv - directed self-checking bench for sram_rw_ctrl
module tb_sram_rw_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst = 1'b1;

  logic       req_valid = 1'b0, req_we = 1'b0, req_wdata = 1'b0;
  logic [1:0] req_addr = 2'd0;
  logic       req_ready, pre_en, rsp_valid, rsp_rdata, rsp_err;
  logic [3:0] row_wr, row_rd;
  real        bl_wr, blb_wr, bl_rd, blb_rd;

  logic       o_valid = 1'b0, o_we = 1'b0, o_wdata = 1'b0;
  logic [1:0] o_addr = 2'd0;
  logic       o_ready, o_pre_en, o_rsp_valid, o_rsp_rdata, o_rsp_err;
  logic [2:0] o_row_wr, o_row_rd;
  real        o_bl_wr, o_blb_wr;
  real        o_bl_rd = 0.0, o_blb_rd = 0.0;

  int checks = 0;
  int errors = 0;

  sram_rw_ctrl #(.ROWS(4)) u_dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .row_wr(row_wr), .row_rd(row_rd), .bl_wr(bl_wr), .blb_wr(blb_wr),
    .pre_en(pre_en), .bl_rd(bl_rd), .blb_rd(blb_rd),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  sram_rw_ctrl #(.ROWS(3)) u_oor (
    .clk(clk), .rst(rst), .req_valid(o_valid), .req_ready(o_ready),
    .req_we(o_we), .req_addr(o_addr), .req_wdata(o_wdata),
    .row_wr(o_row_wr), .row_rd(o_row_rd), .bl_wr(o_bl_wr), .blb_wr(o_blb_wr),
    .pre_en(o_pre_en), .bl_rd(o_bl_rd), .blb_rd(o_blb_rd),
    .rsp_valid(o_rsp_valid), .rsp_rdata(o_rsp_rdata), .rsp_err(o_rsp_err)
  );

  // Behavioural column: cells store on write wordline, drive read bitlines on read wordline.
  logic [3:0] mem = 4'b0000;
  logic       force_eq = 1'b0;
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) if (row_wr[i]) mem[i] <= (bl_wr > blb_wr);
  end
  always_comb begin
    bl_rd  = 1.5;
    blb_rd = 1.5;
    if (force_eq) begin
      bl_rd  = 0.75;
      blb_rd = 0.75;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (row_rd[i]) begin
          bl_rd  = mem[i] ? 1.5 : 0.0;
          blb_rd = mem[i] ? 0.0 : 1.5;
        end
      end
    end
  end

  logic [3:0] tr_wr [1:20];
  logic [3:0] tr_rdl [1:20];
  logic       tr_pre [1:20];
  logic       tr_vld [1:20];
  logic       tr_dat [1:20];
  logic       tr_err [1:20];
  logic       tr_rdy [1:20];
  real        tr_bl  [1:20];
  real        tr_blb [1:20];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_r(input string tag, input real obs, input real exp);
    checks++;
    assert (obs == exp) else begin
      errors++;
      $error("FAIL %s observed=%f expected=%f", tag, obs, exp);
    end
  endtask

  // Waits (bounded) for an idle controller, then presents a request at a falling edge.
  task automatic start(input logic we, input logic [1:0] a, input logic wd);
    int k;
    k = 0;
    while (req_ready !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("ready_wait", 32'(req_ready), 32'd1);
    req_we = we; req_addr = a; req_wdata = wd; req_valid = 1'b1;
  endtask

  // Samples n cycles after E0; cycle c is the one following edge E0+c-1.
  task automatic record(input int n, input int drop_at, input int swap_at,
                        input logic swe, input logic [1:0] sad, input logic swd);
    for (int c = 1; c <= n; c++) begin
      @(negedge clk);
      tr_wr[c] = row_wr; tr_rdl[c] = row_rd; tr_pre[c] = pre_en;
      tr_vld[c] = rsp_valid; tr_dat[c] = rsp_rdata; tr_err[c] = rsp_err;
      tr_rdy[c] = req_ready; tr_bl[c] = bl_wr; tr_blb[c] = blb_wr;
      if (c == drop_at) req_valid = 1'b0;
      if (c == swap_at) begin
        req_we = swe; req_addr = sad; req_wdata = swd;
      end
    end
  endtask

  task automatic chk_write(input string t, input logic [1:0] a, input logic wd);
    logic [3:0] oh;
    oh = 4'b0001 << a;
    for (int c = 1; c <= 10; c++) begin
      chk($sformatf("%s row_wr c%0d", t, c), 32'(tr_wr[c]), (c >= 2 && c <= 5) ? 32'(oh) : 32'd0);
      chk($sformatf("%s row_rd c%0d", t, c), 32'(tr_rdl[c]), 32'd0);
      chk($sformatf("%s pre c%0d", t, c), 32'(tr_pre[c]), 32'd0);
      chk_r($sformatf("%s bl c%0d", t, c), tr_bl[c], (c <= 6) ? (wd ? 1.5 : 0.0) : 0.0);
      chk_r($sformatf("%s blb c%0d", t, c), tr_blb[c], (c <= 6) ? (wd ? 0.0 : 1.5) : 0.0);
      chk($sformatf("%s rsp_valid c%0d", t, c), 32'(tr_vld[c]), (c == 7) ? 32'd1 : 32'd0);
      chk($sformatf("%s ready c%0d", t, c), 32'(tr_rdy[c]), (c >= 8) ? 32'd1 : 32'd0);
    end
    chk({t, " rsp_err"}, 32'(tr_err[7]), 32'd0);
    chk({t, " rsp_rdata"}, 32'(tr_dat[7]), 32'd0);
  endtask

  task automatic chk_read(input string t, input logic [1:0] a, input logic rd, input logic er);
    logic [3:0] oh;
    oh = 4'b0001 << a;
    for (int c = 1; c <= 8; c++) begin
      chk($sformatf("%s pre c%0d", t, c), 32'(tr_pre[c]), (c <= 2) ? 32'd1 : 32'd0);
      chk($sformatf("%s row_rd c%0d", t, c), 32'(tr_rdl[c]), (c >= 3 && c <= 5) ? 32'(oh) : 32'd0);
      chk($sformatf("%s row_wr c%0d", t, c), 32'(tr_wr[c]), 32'd0);
      chk_r($sformatf("%s bl c%0d", t, c), tr_bl[c], 0.0);
      chk_r($sformatf("%s blb c%0d", t, c), tr_blb[c], 0.0);
      chk($sformatf("%s rsp_valid c%0d", t, c), 32'(tr_vld[c]), (c == 6) ? 32'd1 : 32'd0);
      chk($sformatf("%s ready c%0d", t, c), 32'(tr_rdy[c]), (c >= 7) ? 32'd1 : 32'd0);
    end
    chk({t, " rsp_rdata"}, 32'(tr_dat[6]), 32'(rd));
    chk({t, " rsp_err"}, 32'(tr_err[6]), 32'(er));
  endtask

  initial begin
    // Reset state
    @(negedge clk);
    chk("rst ready", 32'(req_ready), 32'd0);
    chk("rst row_wr", 32'(row_wr), 32'd0);
    chk("rst row_rd", 32'(row_rd), 32'd0);
    chk("rst pre", 32'(pre_en), 32'd0);
    chk_r("rst bl", bl_wr, 0.0);
    chk_r("rst blb", blb_wr, 0.0);
    chk("rst rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst rsp_err", 32'(rsp_err), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("post-rst ready", 32'(req_ready), 32'd1);

    // Write 1 / read row 2, write 0 / read row 2, write 1 / read row 1
    start(1'b1, 2'd2, 1'b1); record(10, 1, 0, 1'b0, 2'd0, 1'b0); chk_write("w1r2", 2'd2, 1'b1);
    start(1'b0, 2'd2, 1'b0); record(8, 1, 0, 1'b0, 2'd0, 1'b0);  chk_read("r2a", 2'd2, 1'b1, 1'b0);
    start(1'b1, 2'd2, 1'b0); record(10, 1, 0, 1'b0, 2'd0, 1'b0); chk_write("w0r2", 2'd2, 1'b0);
    start(1'b0, 2'd2, 1'b0); record(8, 1, 0, 1'b0, 2'd0, 1'b0);  chk_read("r2b", 2'd2, 1'b0, 1'b0);
    start(1'b1, 2'd1, 1'b1); record(10, 1, 0, 1'b0, 2'd0, 1'b0); chk_write("w1r1", 2'd1, 1'b1);
    start(1'b0, 2'd1, 1'b0); record(8, 1, 0, 1'b0, 2'd0, 1'b0);  chk_read("r1", 2'd1, 1'b1, 1'b0);

    // Balanced bitlines: error, data repeats last read (1) although row 2 holds 0
    force_eq = 1'b1;
    start(1'b0, 2'd2, 1'b0); record(8, 1, 0, 1'b0, 2'd0, 1'b0);  chk_read("req", 2'd2, 1'b1, 1'b1);
    force_eq = 1'b0;

    // Back-to-back: read row 1 then write 1 row 3 with req_valid held high
    start(1'b0, 2'd1, 1'b0); record(16, 8, 1, 1'b1, 2'd3, 1'b1);
    for (int c = 1; c <= 16; c++) begin
      chk($sformatf("b2b rsp_valid c%0d", c), 32'(tr_vld[c]), (c == 6 || c == 14) ? 32'd1 : 32'd0);
      chk($sformatf("b2b row_wr c%0d", c), 32'(tr_wr[c]), (c >= 9 && c <= 12) ? 32'h8 : 32'd0);
      chk($sformatf("b2b row_rd c%0d", c), 32'(tr_rdl[c]), (c >= 3 && c <= 5) ? 32'h2 : 32'd0);
    end
    for (int c = 1; c <= 8; c++)
      chk($sformatf("b2b ready c%0d", c), 32'(tr_rdy[c]), (c == 7) ? 32'd1 : 32'd0);
    chk("b2b rdata1", 32'(tr_dat[6]), 32'd1);
    chk_r("b2b bl c8", tr_bl[8], 1.5);
    chk("b2b err2", 32'(tr_err[14]), 32'd0);

    // Reset during WR_PULSE
    start(1'b1, 2'd0, 1'b1);
    @(negedge clk); req_valid = 1'b0;
    @(negedge clk);
    chk("mid row_wr before", 32'(row_wr), 32'h1);
    chk_r("mid bl before", bl_wr, 1.5);
    #1 rst = 1'b1;
    #1;
    chk("mid row_wr", 32'(row_wr), 32'd0);
    chk_r("mid bl", bl_wr, 0.0);
    chk_r("mid blb", blb_wr, 0.0);
    chk("mid ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    record(10, 0, 0, 1'b0, 2'd0, 1'b0);
    for (int c = 1; c <= 10; c++) begin
      chk($sformatf("mid rsp_valid c%0d", c), 32'(tr_vld[c]), 32'd0);
      chk($sformatf("mid row_wr c%0d", c), 32'(tr_wr[c]), 32'd0);
    end
    start(1'b1, 2'd3, 1'b0); record(10, 1, 0, 1'b0, 2'd0, 1'b0); chk_write("w0r3", 2'd3, 1'b0);
    start(1'b0, 2'd3, 1'b0); record(8, 1, 0, 1'b0, 2'd0, 1'b0);  chk_read("r3", 2'd3, 1'b0, 1'b0);

    // Out-of-range address on the 3-row instance
    chk("oor ready", 32'(o_ready), 32'd1);
    o_we = 1'b1; o_wdata = 1'b1; o_addr = 2'd3; o_valid = 1'b1;
    @(negedge clk); o_valid = 1'b0;
    chk("oor c1 rsp_valid", 32'(o_rsp_valid), 32'd1);
    chk("oor c1 rsp_err", 32'(o_rsp_err), 32'd1);
    chk("oor c1 rsp_rdata", 32'(o_rsp_rdata), 32'd0);
    chk("oor c1 row_wr", 32'(o_row_wr), 32'd0);
    chk("oor c1 row_rd", 32'(o_row_rd), 32'd0);
    chk("oor c1 pre", 32'(o_pre_en), 32'd0);
    chk_r("oor c1 bl", o_bl_wr, 0.0);
    chk_r("oor c1 blb", o_blb_wr, 0.0);
    chk("oor c1 ready", 32'(o_ready), 32'd0);
    @(negedge clk);
    chk("oor c2 rsp_valid", 32'(o_rsp_valid), 32'd0);
    chk("oor c2 row_wr", 32'(o_row_wr), 32'd0);
    chk_r("oor c2 bl", o_bl_wr, 0.0);
    chk("oor c2 ready", 32'(o_ready), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sram_rw_ctrl.md
Name: sram_rw_ctrl

Overview:
- Clocked sequencer that sits directly upstream of the sram_cell column and drives it.
- Accepts one read or write request at a time over a valid/ready handshake.
- Sequences bitline drive, write wordline pulse, read precharge, read wordline pulse and differential sense of the cell's read bitlines.
- Returns the outcome as a one-cycle response; drives real-valued write bitlines using the codebase supply levels.

Parameters:
- ROWS, 4, number of cells (rows) on the column; AW = $clog2(ROWS), minimum 1.
- WR_CYCLES, 4, cycles row_wr is held high per write (1..255).
- RD_CYCLES, 3, cycles row_rd is held high per read (1..255).
- PRE_CYCLES, 2, cycles pre_en is held high before each read (1..255).
- VDD, 1.5, real high level driven on write bitlines.
- VSS, 0.0, real low level driven on write bitlines.

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous, active-high reset
- req_valid  input  1  request present
- req_ready  output  1  controller idle, can accept
- req_we  input  1  1 = write, 0 = read
- req_addr  input  AW  row index
- req_wdata  input  1  write data
- row_wr  output  ROWS  one-hot write wordlines
- row_rd  output  ROWS  one-hot read wordlines
- bl_wr  output  real  write bitline level
- blb_wr  output  real  complementary write bitline level
- pre_en  output  1  read-bitline precharge enable
- bl_rd  input  real  read bitline from cell
- blb_rd  input  real  complementary read bitline from cell
- rsp_valid  output  1  one-cycle response strobe
- rsp_rdata  output  1  read result (0 for writes)
- rsp_err  output  1  error flag, qualified by rsp_valid

Behaviour:
- Reset (asynchronous, immediate, also mid-operation):
  - state = IDLE; row_wr = row_rd = 0; pre_en = 0.
  - bl_wr = blb_wr = VSS.
  - rsp_valid = rsp_rdata = rsp_err = 0; last_rdata = 0.
  - req_ready goes to 1 in the first cycle after reset is released.
- Handshake:
  - A request is accepted on the rising edge at which req_valid && req_ready (edge E0).
  - req_ready = 1 only in IDLE.
  - req_we, req_addr and req_wdata are registered at E0 and ignored afterwards.
  - There is no response backpressure.
- States: IDLE, WR_SETUP, WR_PULSE, WR_HOLD, RD_PRE, RD_PULSE, RESP.
- Write path (in range):
  - WR_SETUP, 1 cycle: bl_wr = wdata ? VDD : VSS; blb_wr is the complement.
  - WR_PULSE, WR_CYCLES cycles: row_wr[addr] = 1, bitlines held.
  - WR_HOLD, 1 cycle: row_wr = 0, bitlines still held.
  - RESP: bitlines return to VSS/VSS.
  - rsp_valid is high in the cycle after edge E0+WR_CYCLES+2.
- Read path (in range):
  - RD_PRE, PRE_CYCLES cycles: pre_en = 1.
  - RD_PULSE, RD_CYCLES cycles: pre_en = 0, row_rd[addr] = 1.
  - Sense on the edge that ends the last RD_PULSE cycle:
    - bl_rd > blb_rd gives 1; bl_rd < blb_rd gives 0.
    - Equal gives last_rdata and sets rsp_err = 1.
  - RESP: rsp_valid high; the cycle follows edge E0+PRE_CYCLES+RD_CYCLES. last_rdata is updated with the result.
  - Write bitlines stay at VSS/VSS for the whole read.
- Out-of-range address (req_addr >= ROWS):
  - No wordline, precharge or bitline activity.
  - Next state after E0 is RESP with rsp_err = 1 and rsp_rdata = 0.
- RESP lasts exactly 1 cycle, then IDLE; back-to-back requests are accepted on the edge after RESP.
- Invariants:
  - At most one bit of row_wr | row_rd is set at any time.
  - row_wr and row_rd are never high together.
  - pre_en and row_rd are never high together.
- A single 8-bit down-counter times all phases; all outputs are registered.

Test Plan:
- Reset, then write 1 to row 2 (WR_CYCLES=4):
  - row_wr = 4'b0100 for exactly 4 cycles.
  - bl_wr = 1.5 and blb_wr = 0.0 from E0+1 through the WR_HOLD cycle.
  - rsp_valid is a single pulse after edge E0+6 with rsp_err = 0.
- Read row 2 with a behavioural cell model:
  - pre_en high 2 cycles, then row_rd = 4'b0100 for 3 cycles.
  - rsp_rdata = 1 after edge E0+5.
- Write 0 to row 2, then read it back:
  - bl_wr = 0.0 and blb_wr = 1.5 during the write.
  - The read returns rsp_rdata = 0 with rsp_err = 0.
- Read with the model forcing bl_rd == blb_rd = 0.75:
  - rsp_err = 1.
  - rsp_rdata equals the previous read value.
- Back-to-back requests with req_valid held high:
  - Second request accepted on the edge after RESP.
  - req_ready is low throughout the first operation.
- Assert rst during the WR_PULSE cycle:
  - row_wr = 0 and bitlines = VSS immediately (same timestep).
  - No rsp_valid; the next request completes normally.
- Out-of-range address with ROWS=3, req_addr=3:
  - rsp_valid and rsp_err high in the cycle after E0.
  - No row, precharge or bitline activity.
